// File: rtl/tf32_mul2k_pipe.sv
// Two-stage TF32 x 2^shamt scaler with valid/ready flow control and saturation on overflow.
// Optional saturating overflow counter port ovf_cnt is enabled by defining TF32_MUL2K_OVF_CNT_EN.
module tf32_mul2k_pipe #(
    parameter int unsigned SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [18:0]        in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [18:0]        out_data,
`ifdef TF32_MUL2K_OVF_CNT_EN
    output logic               out_ovf,
    output logic [15:0]        ovf_cnt
`else
    output logic               out_ovf
`endif
);

    logic        s1_valid_q, s1_valid_d;
    logic        s1_sign_q, s1_sign_d;
    logic [9:0]  s1_mant_q, s1_mant_d;
    logic        s1_zero_q, s1_zero_d;
    logic [8:0]  s1_exp_sum_q, s1_exp_sum_d;

    logic        s2_valid_q, s2_valid_d;
    logic [18:0] s2_data_q, s2_data_d;
    logic        s2_ovf_q, s2_ovf_d;

    logic        s2_free, s1_free, in_fire, s1_adv;
    logic [18:0] res;
    logic        res_ovf;

    assign s2_free  = ~s2_valid_q | out_ready;
    assign s1_free  = ~s1_valid_q | s2_free;
    assign in_ready = s1_free;
    assign in_fire  = in_valid & s1_free;
    assign s1_adv   = s1_valid_q & s2_free;

    // Stage-2 result: zero drops the sign, overflow clamps to max finite magnitude.
    always_comb begin
        res     = {s1_sign_q, s1_exp_sum_q[7:0], s1_mant_q};
        res_ovf = 1'b0;
        if (s1_zero_q) begin
            res = 19'h00000;
        end else if (s1_exp_sum_q >= 9'd255) begin
            res     = {s1_sign_q, 8'hFE, 10'h3FF};
            res_ovf = 1'b1;
        end
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_sign_d    = s1_sign_q;
        s1_mant_d    = s1_mant_q;
        s1_zero_d    = s1_zero_q;
        s1_exp_sum_d = s1_exp_sum_q;
        s2_valid_d   = s2_valid_q;
        s2_data_d    = s2_data_q;
        s2_ovf_d     = s2_ovf_q;

        if (in_fire) begin
            s1_valid_d   = 1'b1;
            s1_sign_d    = in_data[18];
            s1_mant_d    = in_data[9:0];
            s1_zero_d    = (in_data[17:10] == 8'h00);
            s1_exp_sum_d = {1'b0, in_data[17:10]} + 9'(in_shamt);
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_data_d  = res;
            s2_ovf_d   = res_ovf;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_mant_q    <= 10'h000;
            s1_zero_q    <= 1'b0;
            s1_exp_sum_q <= 9'h000;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= 19'h00000;
            s2_ovf_q     <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_mant_q    <= s1_mant_d;
            s1_zero_q    <= s1_zero_d;
            s1_exp_sum_q <= s1_exp_sum_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_ovf_q     <= s2_ovf_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_ovf   = s2_ovf_q;

`ifdef TF32_MUL2K_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (s2_valid_q && out_ready && s2_ovf_q && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= 16'h0000;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_tf32_mul2k_pipe.sv
// Self-checking bench for tf32_mul2k_pipe: directed table, backpressure, random stream, reset.
module tb_tf32_mul2k_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [18:0] in_data;
    logic [2:0]  in_shamt;
    logic        out_valid;
    logic        out_ready;
    logic [18:0] out_data;
    logic        out_ovf;
`ifdef TF32_MUL2K_OVF_CNT_EN
    logic [15:0] ovf_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_ovf_cnt = 0;

    always #5 clk = ~clk;

    tf32_mul2k_pipe #(.SHAMT_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_shamt (in_shamt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
`ifdef TF32_MUL2K_OVF_CNT_EN
        .out_ovf  (out_ovf),
        .ovf_cnt  (ovf_cnt)
`else
        .out_ovf  (out_ovf)
`endif
    );

    typedef struct {
        logic [18:0] d;
        logic [2:0]  sh;
        logic [18:0] exp_d;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Value-level model: scale by 2^sh in unbiased exponent space, clamp beyond TF32 range.
    function automatic logic [19:0] model(input logic [18:0] d, input int sh);
        int unb;
        if (d[17:10] == 8'h00) return 20'h00000;
        unb = int'(d[17:10]) - 127 + sh;
        if (unb > 127) return {1'b1, d[18], 8'hFE, 10'h3FF};
        return {1'b0, d[18], 8'(unb + 127), d[9:0]};
    endfunction

    function automatic logic [18:0] rand_op();
        int r;
        logic [7:0] e;
        r = $urandom_range(0, 9);
        if (r == 0) return {1'($urandom), 18'h00000};
        e = (r < 4) ? 8'($urandom_range(245, 254)) : 8'($urandom_range(1, 254));
        return {1'($urandom), e, 10'($urandom)};
    endfunction

    vec_t        vecs[7];
    logic [18:0] bp_ops[4];
    logic [19:0] bp_exp[4];
    logic [19:0] q[$];
    logic [19:0] e;
    int          sent, got, cyc;
    logic        started, held, held_ovf;
    logic [18:0] held_data;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{19'h1FC00, 3'd1, 19'h20000, 1'b0};
        vecs[1] = '{19'h5FE00, 3'd3, 19'h60A00, 1'b0};
        vecs[2] = '{19'h5FE00, 3'd0, 19'h5FE00, 1'b0};
        vecs[3] = '{19'h3F800, 3'd1, 19'h3FBFF, 1'b1};
        vecs[4] = '{19'h7F800, 3'd7, 19'h7FBFF, 1'b1};
        vecs[5] = '{19'h40000, 3'd5, 19'h00000, 1'b0};
        vecs[6] = '{19'h00000, 3'd7, 19'h00000, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors, one at a time, verifying the two-cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = vecs[i].d; in_shamt = vecs[i].sh;
            @(negedge clk);
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check($sformatf("vec%0d_lat1_valid", i), 32'(out_valid), 32'd0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp_d));
            check($sformatf("vec%0d_ovf", i), 32'(out_ovf), 32'(vecs[i].exp_ovf));
            if (vecs[i].exp_ovf) exp_ovf_cnt++;
            @(posedge clk); #1;
        end
`ifdef TF32_MUL2K_OVF_CNT_EN
        check("ovf_cnt_directed", 32'(ovf_cnt), 32'd2);
`endif

        // Backpressure: four operands, out_ready low for five cycles.
        bp_ops[0] = 19'h1FC00; bp_ops[1] = 19'h5FE00; bp_ops[2] = 19'h3F800; bp_ops[3] = 19'h20155;
        for (int i = 0; i < 4; i++) bp_exp[i] = model(bp_ops[i], 2);
        in_shamt = 3'd2; out_ready = 1'b0; sent = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            in_valid = (sent < 4);
            in_data  = bp_ops[sent & 3];
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (c >= 2) begin
                check($sformatf("bp_hold_valid_c%0d", c), 32'(out_valid), 32'd1);
                check($sformatf("bp_hold_data_c%0d", c), 32'(out_data), 32'(bp_exp[0][18:0]));
            end
        end
        check("bp_accepted", sent, 32'd2);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        got = 0; started = 1'b0; cyc = 0;
        while (got < 4 && cyc < 20) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid  = (sent < 4);
            in_data   = bp_ops[sent & 3];
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (started) check($sformatf("bp_no_gap_%0d", got), 32'(out_valid), 32'd1);
            if (out_valid && out_ready) begin
                started = 1'b1;
                check($sformatf("bp_order_data_%0d", got), 32'(out_data), 32'(bp_exp[got][18:0]));
                check($sformatf("bp_order_ovf_%0d", got), 32'(out_ovf), 32'(bp_exp[got][19]));
                if (bp_exp[got][19]) exp_ovf_cnt++;
                got++;
            end
            cyc++;
        end
        check("bp_all_out", got, 32'd4);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Random stream with random backpressure against the scoreboard.
        held = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = rand_op();
            in_shamt  = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (held) begin
                check("rand_hold_valid", 32'(out_valid), 32'd1);
                check("rand_hold_data", 32'({held_ovf, held_data}), 32'({out_ovf, out_data}));
            end
            if (in_valid && in_ready) q.push_back(model(in_data, int'(in_shamt)));
            if (out_valid && out_ready) begin
                check("rand_q_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("rand_result", 32'({out_ovf, out_data}), 32'(e));
                    if (e[19]) exp_ovf_cnt++;
                end
            end
            held = out_valid && !out_ready;
            held_data = out_data; held_ovf = out_ovf;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() != 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                e = q.pop_front();
                check("drain_result", 32'({out_ovf, out_data}), 32'(e));
                if (e[19]) exp_ovf_cnt++;
            end
            @(posedge clk); #1;
        end
        check("drain_empty", q.size(), 32'd0);
        @(posedge clk); #1;
`ifdef TF32_MUL2K_OVF_CNT_EN
        check("ovf_cnt_total", 32'(ovf_cnt), 32'(exp_ovf_cnt));
`endif

        // Reset mid-flight: two operands in the pipe, reset between edges.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 19'h1FC00; in_shamt = 3'd1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_out_ovf", 32'(out_ovf), 32'd0);
`ifdef TF32_MUL2K_OVF_CNT_EN
        check("mid_rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check($sformatf("post_rst_no_stale_%0d", c), 32'(out_valid), 32'd0);
            check($sformatf("post_rst_in_ready_%0d", c), 32'(in_ready), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
